conv_result_writer: RTL

Collects the result stream of the first convolution stage and writes it into the feature-map result RAM. Each window is CH beats long. At every window boundary the block issues the `conv_time` / `conv_end` handshake, which lets the input feeder launch the next window. It sits between the conv engine output and the next layer's buffer, and is the write-side counterpart of the input-data reader.

---
 rtl/cnn_cfg_pkg.sv | 23 ++
 rtl/conv_result_writer_win_counter.sv | 74 +++++++
 rtl/conv_result_writer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/cnn_cfg_pkg.sv
// Shared constants and the writer state encoding for the conv stage.
// The input reader and the result writer both use these values.
package cnn_cfg_pkg;

    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 15;
    localparam int CH      = 32;
    localparam int ROW_WIN = 61;
    localparam int MAX_WIN = 672;
    localparam int TIME_W  = 13;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_END     = 2'd2,
        S_DONE    = 2'd3
    } wr_state_e;

    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/conv_result_writer_win_counter.sv
// Beat, column and window counters for the result writer.
// Each counter has a terminal-count flag.
module win_counter
    import cnn_cfg_pkg::*;
#(
    parameter int CH      = cnn_cfg_pkg::CH,
    parameter int ROW_WIN = cnn_cfg_pkg::ROW_WIN,
    parameter int MAX_WIN = cnn_cfg_pkg::MAX_WIN,
    localparam int BEAT_W = cnt_w(CH),
    localparam int COL_W  = cnt_w(ROW_WIN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              beat_inc,
    output logic [BEAT_W-1:0] beat_cnt,
    output logic              beat_last,
    output logic              col_last,
    output logic [TIME_W-1:0] conv_time,
    output logic              time_last,
    output logic              time_full
);

    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [COL_W-1:0]  col_cnt_q, col_cnt_d;
    logic [TIME_W-1:0] conv_time_q, conv_time_d;

    assign beat_last = (beat_cnt_q == BEAT_W'(CH - 1));
    assign col_last  = (col_cnt_q == COL_W'(ROW_WIN - 1));
    assign time_last = (conv_time_q == TIME_W'(MAX_WIN - 1));
    assign time_full = (conv_time_q == TIME_W'(MAX_WIN));

    always_comb begin
        beat_cnt_d  = beat_cnt_q;
        col_cnt_d   = col_cnt_q;
        conv_time_d = conv_time_q;
        if (clr) begin
            beat_cnt_d  = '0;
            col_cnt_d   = '0;
            conv_time_d = '0;
        end else if (beat_inc) begin
            if (beat_last) begin
                beat_cnt_d = '0;
                if (!time_full) begin
                    conv_time_d = conv_time_q + 1'b1;
                end
                // col_cnt counts completed windows within the row
                if (col_last) begin
                    col_cnt_d = '0;
                end else begin
                    col_cnt_d = col_cnt_q + 1'b1;
                end
            end else begin
                beat_cnt_d = beat_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_q  <= '0;
            col_cnt_q   <= '0;
            conv_time_q <= '0;
        end else begin
            beat_cnt_q  <= beat_cnt_d;
            col_cnt_q   <= col_cnt_d;
            conv_time_q <= conv_time_d;
        end
    end

    assign beat_cnt  = beat_cnt_q;
    assign conv_time = conv_time_q;

endmodule

// File: rtl/conv_result_writer.sv
// Writes the conv-stage result stream into the feature-map RAM and issues
// the per-window conv_end / conv_time handshake to the input feeder.
//
// state   | meaning
// IDLE    | waiting for start; beats are dropped and flagged
// COLLECT | accepting beats of the current window
// END     | window just completed; conv_end high; beat here opens the next window
// DONE    | all windows written; layer_done high; beats dropped and flagged
module conv_result_writer
    import cnn_cfg_pkg::*;
#(
    parameter int DATA_W  = cnn_cfg_pkg::DATA_W,
    parameter int ADDR_W  = cnn_cfg_pkg::ADDR_W,
    parameter int CH      = cnn_cfg_pkg::CH,
    parameter int ROW_WIN = cnn_cfg_pkg::ROW_WIN,
    parameter int MAX_WIN = cnn_cfg_pkg::MAX_WIN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              out_valid,
    input  logic [DATA_W-1:0] out_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [TIME_W-1:0] conv_time,
    output logic              conv_end,
    output logic              row_end,
    output logic              layer_done,
    output logic              overflow,
    output logic              busy
);

    localparam int BEAT_W = cnt_w(CH);

    wr_state_e         state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              conv_end_q, conv_end_d;
    logic              row_end_q, row_end_d;
    logic              overflow_q, overflow_d;

    logic              accept;
    logic              win_done;
    logic [BEAT_W-1:0] beat_cnt;
    logic              beat_last;
    logic              col_last;
    logic              time_last;
    logic              time_full;

    win_counter #(
        .CH      (CH),
        .ROW_WIN (ROW_WIN),
        .MAX_WIN (MAX_WIN)
    ) u_win_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (start),
        .beat_inc  (accept),
        .beat_cnt  (beat_cnt),
        .beat_last (beat_last),
        .col_last  (col_last),
        .conv_time (conv_time),
        .time_last (time_last),
        .time_full (time_full)
    );

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_COLLECT;
            end
            S_COLLECT: begin
                accept = out_valid && !start;
                if (start) begin
                    state_d = S_COLLECT;
                end else if (accept && beat_last) begin
                    state_d = S_END;
                end
            end
            S_END: begin
                // once the final window closes, nothing more is accepted
                accept = out_valid && !start && !time_full;
                if (start) begin
                    state_d = S_COLLECT;
                end else if (time_full) begin
                    state_d = S_DONE;
                end else if (accept && beat_last) begin
                    state_d = S_END;
                end else begin
                    state_d = S_COLLECT;
                end
            end
            S_DONE: begin
                if (start) state_d = S_COLLECT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign win_done = accept && beat_last;

    always_comb begin
        base_d     = base_q;
        wr_en_d    = accept;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        conv_end_d = win_done;
        row_end_d  = win_done && col_last;
        overflow_d = overflow_q;

        if (accept) begin
            wr_addr_d = base_q + ADDR_W'(beat_cnt);
            wr_data_d = out_data;
        end

        if (start) begin
            base_d     = '0;
            overflow_d = 1'b0;
        end else begin
            // base stops at the last window so it never wraps past the RAM
            if (win_done && !time_last) begin
                base_d = base_q + ADDR_W'(CH);
            end
            if (out_valid && !accept) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            conv_end_q <= 1'b0;
            row_end_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            conv_end_q <= conv_end_d;
            row_end_q  <= row_end_d;
            overflow_q <= overflow_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign conv_end   = conv_end_q;
    assign row_end    = row_end_q;
    assign overflow   = overflow_q;
    assign layer_done = (state_q == S_DONE);
    assign busy       = (state_q == S_COLLECT) || (state_q == S_END);

endmodule
